scan_ctrl: RTL and testbench

Sequencer for the CSOC full-scan chain. Accepts a pattern count and a serial bit stream from the test host, then drives the chain's scan-enable, test-mode and serial-in pins through repeated shift/capture phases. Returns the unloaded response bits to the host. Sits between the host-side test interface (UART bridge or bench) and the chip's `test_se_i`, `test_tm_i`, `data_i[0]` and scan-out pins.

---
 rtl/csoc_test_pkg.sv | 19 +
 rtl/scan_cnt.sv | 33 +++
 rtl/scan_ctrl.sv | 178 +++++++++++++++++
 tb/tb_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/csoc_test_pkg.sv
// Shared types and helpers for the CSOC scan test logic.
package csoc_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_UNLOAD  = 3'd3,
    ST_DONE    = 3'd4
  } scan_state_t;

  localparam int NREGS_DEFAULT = 1918;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/scan_cnt.sv
// Loadable down-counter that saturates at zero; flags zero and one.
module scan_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         zero_o,
  output logic         last_o
);

  logic [W-1:0] r_cnt;

  // Clear beats load beats decrement; never wraps below zero.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (load_i) begin
      r_cnt <= load_val_i;
    end else if (en_i && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero_o = (r_cnt == '0);
  assign last_o = (r_cnt == W'(1));

endmodule

// File: rtl/scan_ctrl.sv
// Full-scan chain sequencer: load/capture/unload with host handshakes.
module scan_ctrl
  import csoc_test_pkg::*;
#(
  parameter int NREGS      = NREGS_DEFAULT,
  parameter int CAP_CYCLES = 1,
  parameter int PAT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [PAT_W-1:0] npat_i,
  input  logic             abort_i,
  input  logic             si_valid_i,
  input  logic             si_bit_i,
  output logic             si_ready_o,
  output logic             so_valid_o,
  output logic             so_bit_o,
  input  logic             so_ready_i,
  output logic             scan_se_o,
  output logic             scan_tm_o,
  output logic             scan_si_o,
  input  logic             scan_so_i,
  output logic             busy_o,
  output logic             done_o
);

  // The bit counter doubles as the capture timer, so it must hold both.
  localparam int BIT_W = cnt_w((NREGS > CAP_CYCLES) ? NREGS : CAP_CYCLES);
  localparam logic [BIT_W-1:0] NREGS_V = BIT_W'(NREGS);
  localparam logic [BIT_W-1:0] CAP_V   = BIT_W'(CAP_CYCLES);

  scan_state_t r_state, w_state_next;
  logic r_first_pat, w_first_pat_next;
  logic r_zero_run, w_zero_run_next;

  logic             w_fire, w_si_ready, w_so_valid, w_so_bit, w_scan_si, w_done;
  logic             w_bit_load, w_bit_en, w_bit_zero, w_bit_last;
  logic [BIT_W-1:0] w_bit_val;
  logic             w_pat_load, w_pat_en, w_pat_zero, w_pat_last, w_pat_more;

  scan_cnt #(.W(BIT_W)) u_bit_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (abort_i),
    .load_i     (w_bit_load),
    .load_val_i (w_bit_val),
    .en_i       (w_bit_en),
    .zero_o     (w_bit_zero),
    .last_o     (w_bit_last)
  );

  scan_cnt #(.W(PAT_W)) u_pat_cnt (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .clr_i      (abort_i),
    .load_i     (w_pat_load),
    .load_val_i (npat_i),
    .en_i       (w_pat_en),
    .zero_o     (w_pat_zero),
    .last_o     (w_pat_last)
  );

  // Checked before the decrement: more patterns follow unless this was the last.
  assign w_pat_more = !w_pat_zero && !w_pat_last;

  // State register plus the first-pattern and zero-run flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state     <= ST_IDLE;
      r_first_pat <= 1'b0;
      r_zero_run  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_first_pat <= w_first_pat_next;
      r_zero_run  <= w_zero_run_next;
    end
  end

  // Next-state, handshake and counter control; abort overrides everything.
  always_comb begin
    w_state_next     = r_state;
    w_first_pat_next = r_first_pat;
    w_zero_run_next  = r_zero_run;
    w_fire           = 1'b0;
    w_si_ready       = 1'b0;
    w_so_valid       = 1'b0;
    w_so_bit         = 1'b0;
    w_scan_si        = 1'b0;
    w_done           = 1'b0;
    w_bit_load       = 1'b0;
    w_bit_val        = NREGS_V;
    w_bit_en         = 1'b0;
    w_pat_load       = 1'b0;
    w_pat_en         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          if (npat_i != '0) begin
            w_state_next     = ST_LOAD;
            w_bit_load       = 1'b1;
            w_pat_load       = 1'b1;
            w_first_pat_next = 1'b1;
            w_zero_run_next  = 1'b0;
          end else begin
            w_state_next    = ST_DONE;
            w_zero_run_next = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        // The first pattern has no response behind it, so only si gates the shift.
        w_si_ready = r_first_pat || so_ready_i;
        w_so_valid = !r_first_pat && si_valid_i;
        w_so_bit   = !r_first_pat && scan_so_i;
        w_fire     = si_valid_i && w_si_ready;
        w_scan_si  = w_fire && si_bit_i;
        w_bit_en   = w_fire;
        if (w_fire && w_bit_last) begin
          w_state_next = ST_CAPTURE;
          w_bit_load   = 1'b1;
          w_bit_val    = CAP_V;
        end
      end
      ST_CAPTURE: begin
        w_bit_en = 1'b1;
        if (w_bit_last || w_bit_zero) begin
          w_pat_en         = 1'b1;
          w_bit_load       = 1'b1;
          w_bit_val        = NREGS_V;
          w_first_pat_next = 1'b0;
          w_state_next     = w_pat_more ? ST_LOAD : ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        w_so_valid = 1'b1;
        w_so_bit   = scan_so_i;
        w_fire     = so_ready_i;
        w_bit_en   = w_fire;
        if (w_fire && w_bit_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (abort_i) begin
      w_state_next     = ST_IDLE;
      w_first_pat_next = 1'b0;
      w_zero_run_next  = 1'b0;
      w_fire           = 1'b0;
      w_si_ready       = 1'b0;
      w_so_valid       = 1'b0;
      w_scan_si        = 1'b0;
      w_done           = 1'b0;
      w_bit_load       = 1'b0;
      w_bit_en         = 1'b0;
      w_pat_load       = 1'b0;
      w_pat_en         = 1'b0;
    end
  end

  assign scan_se_o  = w_fire;
  assign scan_si_o  = w_scan_si;
  assign si_ready_o = w_si_ready;
  assign so_valid_o = w_so_valid;
  assign so_bit_o   = w_so_bit;
  assign done_o     = w_done;
  assign busy_o     = (r_state != ST_IDLE);
  // A zero-pattern request never touches the chain, so test mode stays low.
  assign scan_tm_o  = busy_o && !((r_state == ST_DONE) && r_zero_run);

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl with a behavioural scan chain whose capture inverts all bits.
module tb_scan_ctrl;

  localparam int NREGS = 8;
  localparam int CAPC  = 1;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] npat_i = '0;
  logic        abort_i = 1'b0;
  logic        si_valid_i = 1'b0;
  logic        si_bit_i = 1'b0;
  logic        so_ready_i = 1'b0;
  logic        si_ready_o, so_valid_o, so_bit_o;
  logic        scan_se_o, scan_tm_o, scan_si_o, scan_so_i;
  logic        busy_o, done_o;

  int errors = 0;
  int checks = 0;

  scan_ctrl #(.NREGS(NREGS), .CAP_CYCLES(CAPC), .PAT_W(16)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .start_i    (start_i),
    .npat_i     (npat_i),
    .abort_i    (abort_i),
    .si_valid_i (si_valid_i),
    .si_bit_i   (si_bit_i),
    .si_ready_o (si_ready_o),
    .so_valid_o (so_valid_o),
    .so_bit_o   (so_bit_o),
    .so_ready_i (so_ready_i),
    .scan_se_o  (scan_se_o),
    .scan_tm_o  (scan_tm_o),
    .scan_si_o  (scan_si_o),
    .scan_so_i  (scan_so_i),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // Behavioural chain: shifts on scan enable; after each loaded pattern, capture inverts it.
  logic [NREGS-1:0] chain = '0;
  int chain_shifts = 0;
  int model_npat = 0;
  always @(posedge clk) begin
    if (scan_se_o) begin
      chain <= (((chain_shifts + 1) % NREGS == 0) && ((chain_shifts + 1) / NREGS <= model_npat))
               ? ~{chain[NREGS-2:0], scan_si_o} : {chain[NREGS-2:0], scan_si_o};
      chain_shifts <= chain_shifts + 1;
    end
    if (start_i && !busy_o) chain_shifts <= 0;
  end
  assign scan_so_i = chain[NREGS-1];

  // Results of the last driven run
  logic sent_q[$];
  logic recv_q[$];
  logic arr_se[0:1023], arr_sir[0:1023], arr_tm[0:1023], arr_busy[0:1023];
  int   done_cyc, overlap, se_bad, nbad;
  logic post_done, post_busy;
  logic [63:0] fixed_bits = '0;

  // Drives one run: vmode/rmode are percentages, -1 selects the scripted pattern.
  task automatic drive_run(input int npat, input int vmode, input int rmode, input int fixed,
                           input int abort_at, input int restart_at, input int budget);
    logic hs_in, hs_out;
    sent_q.delete(); recv_q.delete();
    done_cyc = -1; overlap = 0; se_bad = 0;
    model_npat = npat;
    @(negedge clk);
    start_i = 1'b1; npat_i = 16'(npat); abort_i = 1'b0; si_valid_i = 1'b0; so_ready_i = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      @(negedge clk);
      start_i    = (cyc == restart_at);
      npat_i     = (cyc == restart_at) ? 16'd5 : 16'(npat);
      abort_i    = (cyc == abort_at);
      si_valid_i = (vmode < 0) ? (cyc % 2 == 0) : (int'($urandom_range(99)) < vmode);
      si_bit_i   = (fixed != 0) ? fixed_bits[sent_q.size() % 64] : 1'($urandom_range(1));
      so_ready_i = (rmode < 0) ? !(cyc >= 12 && cyc <= 15) : (int'($urandom_range(99)) < rmode);
      #1;
      arr_se[cyc] = scan_se_o; arr_sir[cyc] = si_ready_o;
      arr_tm[cyc] = scan_tm_o; arr_busy[cyc] = busy_o;
      if (done_o) begin
        done_cyc = cyc;
        break;
      end
      hs_in  = si_valid_i && si_ready_o;
      hs_out = so_valid_o && so_ready_i;
      if (hs_in) sent_q.push_back(si_bit_i);
      if (hs_out) begin
        recv_q.push_back(so_bit_o);
        if (hs_in) overlap++;
      end
      if (scan_se_o !== (hs_in || hs_out)) se_bad++;
    end
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0; si_valid_i = 1'b0; so_ready_i = 1'b0;
    #1;
    post_done = done_o; post_busy = busy_o;
    nbad = 0;
    for (int i = 0; i < recv_q.size() && i < sent_q.size(); i++)
      if (recv_q[i] !== ~sent_q[i]) nbad++;
    $display("run npat=%0d done_cyc=%0d sent=%0d recv=%0d overlap=%0d", npat, done_cyc,
             sent_q.size(), recv_q.size(), overlap);
  endtask

  task automatic test_reset();
    logic [7:0] outs;
    rstn_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    outs = {scan_se_o, scan_tm_o, scan_si_o, si_ready_o, so_valid_o, so_bit_o, busy_o, done_o};
    checks++;
    if (outs !== 8'h00) begin errors++; $display("FAIL reset_outputs: got %b expected 00000000", outs); end
    rstn_i = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy_o); end
  endtask

  task automatic test_single();
    logic [7:0] so_byte;
    fixed_bits = 64'hA5;
    drive_run(1, 100, 100, 1, 0, 0, 60);
    so_byte = '0;
    for (int i = 0; i < 8 && i < recv_q.size(); i++) so_byte[i] = recv_q[i];
    checks++;
    if (so_byte !== 8'h5A || recv_q.size() != 8) begin
      errors++; $display("FAIL single_so_stream: got %h (n=%0d) expected 5a (n=8)", so_byte, recv_q.size());
    end
    checks++;
    if (done_cyc != 18) begin errors++; $display("FAIL single_done_cycle: got %0d expected 18", done_cyc); end
    checks++;
    if (arr_tm[1] !== 1'b1 || arr_tm[18] !== 1'b1 || arr_busy[1] !== 1'b1) begin
      errors++; $display("FAIL single_tm_busy: got tm1=%b tm18=%b busy1=%b expected 1 1 1", arr_tm[1], arr_tm[18], arr_busy[1]);
    end
    checks++;
    if (post_done !== 1'b0 || post_busy !== 1'b0) begin
      errors++; $display("FAIL single_done_pulse: got done=%b busy=%b expected 0 0", post_done, post_busy);
    end
    checks++;
    if (se_bad != 0 || overlap != 0) begin
      errors++; $display("FAIL single_se_rule: got se_bad=%0d overlap=%0d expected 0 0", se_bad, overlap);
    end
  endtask

  task automatic test_ignored_start();
    fixed_bits = 64'h3C;
    drive_run(1, 100, 100, 1, 0, 3, 60);
    checks++;
    if (done_cyc != 18 || recv_q.size() != 8 || nbad != 0) begin
      errors++; $display("FAIL ignored_start: got done=%0d recv=%0d bad=%0d expected 18 8 0", done_cyc, recv_q.size(), nbad);
    end
  endtask

  task automatic test_zero();
    drive_run(0, 100, 100, 0, 0, 0, 20);
    checks++;
    if (done_cyc != 1) begin errors++; $display("FAIL zero_done_cycle: got %0d expected 1", done_cyc); end
    checks++;
    if (arr_tm[1] !== 1'b0 || recv_q.size() != 0 || sent_q.size() != 0) begin
      errors++; $display("FAIL zero_no_scan: got tm=%b sent=%0d recv=%0d expected 0 0 0", arr_tm[1], sent_q.size(), recv_q.size());
    end
    checks++;
    if (post_busy !== 1'b0) begin errors++; $display("FAIL zero_idle_after: got busy=%b expected 0", post_busy); end
  endtask

  task automatic test_stalls();
    drive_run(2, -1, 100, 0, 0, 0, 200);
    checks++;
    if (sent_q.size() != 2 * NREGS || recv_q.size() != 2 * NREGS || nbad != 0) begin
      errors++; $display("FAIL stalls_stream: got sent=%0d recv=%0d bad=%0d expected 16 16 0", sent_q.size(), recv_q.size(), nbad);
    end
    checks++;
    if (overlap != NREGS) begin errors++; $display("FAIL stalls_overlap: got %0d expected %0d", overlap, NREGS); end
    checks++;
    if (done_cyc < 0 || se_bad != 0) begin
      errors++; $display("FAIL stalls_done_se: got done=%0d se_bad=%0d expected done>0 se_bad=0", done_cyc, se_bad);
    end
  endtask

  task automatic test_backpressure();
    int stalled;
    drive_run(2, 100, -1, 0, 0, 0, 100);
    stalled = 0;
    for (int c = 12; c <= 15; c++) if (arr_sir[c] === 1'b0 && arr_se[c] === 1'b0) stalled++;
    checks++;
    if (stalled != 4) begin errors++; $display("FAIL bp_stalled_cycles: got %0d expected 4", stalled); end
    checks++;
    if (arr_se[11] !== 1'b1 || arr_se[16] !== 1'b1) begin
      errors++; $display("FAIL bp_edges: got se11=%b se16=%b expected 1 1", arr_se[11], arr_se[16]);
    end
    checks++;
    if (done_cyc != 31 || nbad != 0 || recv_q.size() != 16 || overlap != NREGS) begin
      errors++; $display("FAIL bp_run: got done=%0d bad=%0d recv=%0d overlap=%0d expected 31 0 16 8", done_cyc, nbad, recv_q.size(), overlap);
    end
  endtask

  task automatic test_abort();
    drive_run(1, 100, 100, 0, 6, 0, 25);
    checks++;
    if (arr_se[6] !== 1'b0) begin errors++; $display("FAIL abort_se_same_cycle: got %b expected 0", arr_se[6]); end
    checks++;
    if (arr_busy[7] !== 1'b0 || arr_se[7] !== 1'b0 || arr_tm[7] !== 1'b0) begin
      errors++; $display("FAIL abort_idle: got busy=%b se=%b tm=%b expected 0 0 0", arr_busy[7], arr_se[7], arr_tm[7]);
    end
    checks++;
    if (done_cyc != -1) begin errors++; $display("FAIL abort_no_done: got done at %0d expected none", done_cyc); end
    checks++;
    if (chain_shifts != 5 || sent_q.size() != 5) begin
      errors++; $display("FAIL abort_shift_count: got chain=%0d sent=%0d expected 5 5", chain_shifts, sent_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] outs;
    model_npat = 1;
    @(negedge clk);
    start_i = 1'b1; npat_i = 16'd1; si_valid_i = 1'b1; si_bit_i = 1'b1; so_ready_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++;
    if (busy_o !== 1'b1 || scan_tm_o !== 1'b1 || scan_se_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_capture: got busy=%b tm=%b se=%b expected 1 1 0", busy_o, scan_tm_o, scan_se_o);
    end
    rstn_i = 1'b0;
    #1;
    outs = {scan_se_o, scan_tm_o, scan_si_o, si_ready_o, so_valid_o, so_bit_o, busy_o, done_o};
    checks++;
    if (outs !== 8'h00) begin errors++; $display("FAIL rstmid_outputs: got %b expected 00000000", outs); end
    @(negedge clk); @(negedge clk);
    rstn_i = 1'b1; si_valid_i = 1'b0; so_ready_i = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (busy_o !== 1'b0 || scan_tm_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_idle: got busy=%b tm=%b expected 0 0", busy_o, scan_tm_o);
    end
  endtask

  task automatic test_random();
    int np;
    for (int r = 0; r < 3; r++) begin
      np = int'($urandom_range(3, 1));
      drive_run(np, 70, 70, 0, 0, 0, 800);
      checks++;
      if (done_cyc < 0 || sent_q.size() != np * NREGS || recv_q.size() != np * NREGS || nbad != 0 || se_bad != 0) begin
        errors++;
        $display("FAIL random_run%0d: got done=%0d sent=%0d recv=%0d bad=%0d se_bad=%0d expected done>0 %0d %0d 0 0",
                 r, done_cyc, sent_q.size(), recv_q.size(), nbad, se_bad, np * NREGS, np * NREGS);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ignored_start();
    test_zero();
    test_stalls();
    test_backpressure();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
